multdiv_stage: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit in the execute stage, alongside the single-cycle ALU.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_stage_if.sv | 27 ++
 rtl/multdiv_stage_booth_mult_core.sv | 64 ++++++
 rtl/multdiv_stage.sv | 152 +++++++++++++++
 tb/tb_multdiv_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide stage.
// MULTDIV_RADIX4_EN selects the radix-4 multiply schedule (16 iterations instead of 32).
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

`ifdef MULTDIV_RADIX4_EN
   localparam int ITER_MULT = 16;
`else
   localparam int ITER_MULT = 32;
`endif
   localparam int ITER_DIV = 32;
   localparam int CNT_BITS = 6;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_stage_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_stage_if #(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 5
);
   logic                ctrl_MULT;
   logic                ctrl_DIV;
   logic                flush;
   logic [WIDTH-1:0]    data_operandA;
   logic [WIDTH-1:0]    data_operandB;
   logic [REG_BITS-1:0] dest_in;
   logic [WIDTH-1:0]    data_result;
   logic                data_exception;
   logic                data_resultRDY;
   logic [REG_BITS-1:0] dest_out;
   logic                busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB, dest_in,
      input  data_result, data_exception, data_resultRDY, dest_out, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB, dest_in,
      output data_result, data_exception, data_resultRDY, dest_out, busy
   );
endinterface

// File: rtl/multdiv_stage_booth_mult_core.sv
// Booth multiplier iteration datapath; exposes the post-step product so the caller can capture it on the last edge.
// MULTDIV_RADIX4_EN selects radix-4 (2 bits per step), otherwise radix-2 (1 bit per step).
module booth_mult_core #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic [WIDTH-1:0] product_lo_next,
   output logic             overflow_next
);
   // Two guard bits keep +/-2M exact even for the most negative multiplicand.
   localparam int AW = WIDTH + 2;

   logic signed [AW-1:0] acc_reg;
   logic signed [AW-1:0] m_reg;
   logic [WIDTH-1:0]     q_reg;
   logic                 q_m1_reg;

   logic signed [AW-1:0] acc_sum;
   logic signed [AW-1:0] acc_next;
   logic [WIDTH-1:0]     q_next;
   logic                 q_m1_next;

   always_comb begin
      acc_sum = acc_reg;
`ifdef MULTDIV_RADIX4_EN
      case ({q_reg[1:0], q_m1_reg})
         3'b001, 3'b010: acc_sum = acc_reg + m_reg;
         3'b011:         acc_sum = acc_reg + (m_reg <<< 1);
         3'b100:         acc_sum = acc_reg - (m_reg <<< 1);
         3'b101, 3'b110: acc_sum = acc_reg - m_reg;
         default:        acc_sum = acc_reg;
      endcase
      {acc_next, q_next, q_m1_next} = $signed({acc_sum, q_reg, q_m1_reg}) >>> 2;
`else
      case ({q_reg[0], q_m1_reg})
         2'b01:   acc_sum = acc_reg + m_reg;
         2'b10:   acc_sum = acc_reg - m_reg;
         default: acc_sum = acc_reg;
      endcase
      {acc_next, q_next, q_m1_next} = $signed({acc_sum, q_reg, q_m1_reg}) >>> 1;
`endif
   end

   assign product_lo_next = q_next;
   // Product fits in WIDTH signed bits only if the whole high part mirrors the low word's sign.
   assign overflow_next   = (acc_next != {AW{q_next[WIDTH-1]}});

   always_ff @(posedge clock) begin
      if (load) begin
         acc_reg  <= '0;
         m_reg    <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
         q_reg    <= multiplier;
         q_m1_reg <= 1'b0;
      end else if (step) begin
         acc_reg  <= acc_next;
         q_reg    <= q_next;
         q_m1_reg <= q_m1_next;
      end
   end
endmodule

// File: rtl/multdiv_stage.sv
// Iterative signed multiply/divide unit for the execute stage: Booth multiply, non-restoring divide.
// MULTDIV_RADIX4_EN shortens the multiply to 16 iterations; divide latency is unaffected.
module multdiv_stage
   import multdiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 5
) (
   input logic            clock,
   input logic            reset,
   multdiv_stage_if.slave bus
);
   state_t                state_reg;
   logic [CNT_BITS-1:0]   cnt_reg;
   logic [REG_BITS-1:0]   dest_pend_reg;
   logic [REG_BITS-1:0]   dest_out_reg;
   logic [WIDTH-1:0]      result_reg;
   logic                  exc_reg;
   logic                  rdy_reg;

   logic signed [WIDTH+1:0] rem_reg;
   logic [WIDTH-1:0]        quo_reg;
   logic [WIDTH-1:0]        dvs_reg;
   logic                    neg_reg;
   logic                    div_zero_reg;
   logic                    div_ovf_reg;

   logic signed [WIDTH+1:0] rem_shift;
   logic signed [WIDTH+1:0] rem_next;
   logic [WIDTH-1:0]        quo_next;
   logic [WIDTH-1:0]        div_result;
   logic [WIDTH-1:0]        mult_lo;
   logic                    mult_ovf;
   logic                    mult_load;
   logic                    cnt_last_mult;
   logic                    cnt_last_div;
   logic [CNT_BITS-1:0]     cnt_sat;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   assign mult_load = (state_reg == IDLE) && bus.ctrl_MULT;

   booth_mult_core #(.WIDTH(WIDTH)) u_booth (
      .clock           (clock),
      .load            (mult_load),
      .step            (state_reg == MULT),
      .multiplicand    (bus.data_operandA),
      .multiplier      (bus.data_operandB),
      .product_lo_next (mult_lo),
      .overflow_next   (mult_ovf)
   );

   // Non-restoring step: the partial remainder sign picks add/subtract; the quotient needs no correction.
   always_comb begin
      rem_shift  = {rem_reg[WIDTH:0], quo_reg[WIDTH-1]};
      rem_next   = rem_reg[WIDTH+1] ? (rem_shift + {2'b00, dvs_reg})
                                    : (rem_shift - {2'b00, dvs_reg});
      quo_next   = {quo_reg[WIDTH-2:0], ~rem_next[WIDTH+1]};
      div_result = neg_reg ? (~quo_next + 1'b1) : quo_next;
   end

   assign cnt_last_mult = (cnt_reg == CNT_BITS'(ITER_MULT - 1));
   assign cnt_last_div  = (cnt_reg == CNT_BITS'(ITER_DIV - 1));
   assign cnt_sat       = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         dest_pend_reg <= '0;
         dest_out_reg  <= '0;
         result_reg    <= '0;
         exc_reg       <= 1'b0;
         rdy_reg       <= 1'b0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         dvs_reg       <= '0;
         neg_reg       <= 1'b0;
         div_zero_reg  <= 1'b0;
         div_ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (bus.ctrl_MULT) begin
                  state_reg     <= MULT;
                  dest_pend_reg <= bus.dest_in;
               end else if (bus.ctrl_DIV) begin
                  state_reg     <= DIV;
                  dest_pend_reg <= bus.dest_in;
                  rem_reg       <= '0;
                  quo_reg       <= mag(bus.data_operandA);
                  dvs_reg       <= mag(bus.data_operandB);
                  neg_reg       <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                  div_zero_reg  <= (bus.data_operandB == '0);
                  div_ovf_reg   <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
               end
            end
            MULT: begin
               if (bus.flush) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_sat;
                  if (cnt_last_mult) begin
                     state_reg    <= DONE;
                     result_reg   <= mult_lo;
                     exc_reg      <= mult_ovf;
                     rdy_reg      <= 1'b1;
                     dest_out_reg <= dest_pend_reg;
                  end
               end
            end
            DIV: begin
               if (bus.flush) begin
                  state_reg <= IDLE;
               end else if (div_zero_reg) begin
                  state_reg    <= DONE;
                  result_reg   <= '0;
                  exc_reg      <= 1'b1;
                  rdy_reg      <= 1'b1;
                  dest_out_reg <= dest_pend_reg;
               end else begin
                  rem_reg <= rem_next;
                  quo_reg <= quo_next;
                  cnt_reg <= cnt_sat;
                  if (cnt_last_div) begin
                     state_reg    <= DONE;
                     result_reg   <= div_result;
                     exc_reg      <= div_ovf_reg;
                     rdy_reg      <= 1'b1;
                     dest_out_reg <= dest_pend_reg;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               rdy_reg   <= 1'b0;
               exc_reg   <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.data_result    = result_reg;
   assign bus.data_exception = exc_reg;
   assign bus.data_resultRDY = rdy_reg;
   assign bus.dest_out       = dest_out_reg;
   assign bus.busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_multdiv_stage.sv
// Directed bench for multdiv_stage: latency, results, exceptions, flush and reset behaviour.
// Multiply latency expectation follows MULTDIV_RADIX4_EN.
module tb_multdiv_stage;
   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

`ifdef MULTDIV_RADIX4_EN
   localparam int MUL_LAT = 16;
`else
   localparam int MUL_LAT = 32;
`endif
   localparam int DIV_LAT = 32;

   multdiv_stage_if #(.WIDTH(32), .REG_BITS(5)) bus ();

   multdiv_stage #(.WIDTH(32), .REG_BITS(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string name, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                         input int exp_lat, input logic [31:0] exp_res, input logic exp_exc,
                         input int pulse_at);
      int   lat;
      logic busy_ok;
      bus.ctrl_MULT     = mul;
      bus.ctrl_DIV      = div;
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.dest_in       = dest;
      tick();
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = ~a;
      bus.data_operandB = ~b;
      bus.dest_in       = ~dest;
      lat     = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         bus.ctrl_MULT = (i == pulse_at);
         tick();
         if (bus.data_resultRDY === 1'b1) begin
            lat = i;
            break;
         end
      end
      bus.ctrl_MULT = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " busy"}, 32'(busy_ok), 32'd1);
      check({name, " result"}, bus.data_result, exp_res);
      check({name, " exc"}, 32'(bus.data_exception), 32'(exp_exc));
      check({name, " dest"}, 32'(bus.dest_out), 32'(dest));
      $display("op %s: a=%08h b=%08h result=%08h exc=%0d dest=%0d lat=%0d",
               name, a, b, bus.data_result, bus.data_exception, bus.dest_out, lat);
      tick();
      check({name, " rdy drop"}, 32'(bus.data_resultRDY), 32'd0);
      check({name, " idle"}, 32'(bus.busy), 32'd0);
      check({name, " exc clr"}, 32'(bus.data_exception), 32'd0);
      check({name, " hold"}, bus.data_result, exp_res);
   endtask

   initial begin
      int seen;
      reset             = 1'b0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.flush         = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.dest_in       = '0;
      tick();
      tick();
      check("rst result", bus.data_result, 32'h0);
      check("rst exc", 32'(bus.data_exception), 32'd0);
      check("rst rdy", 32'(bus.data_resultRDY), 32'd0);
      check("rst dest", 32'(bus.dest_out), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      reset = 1'b1;
      tick();

      run_op("mul 7*-3",     1, 0, 32'd7,          32'hFFFF_FFFD, 5'd5,  MUL_LAT, 32'hFFFF_FFEB, 0, 0);
      run_op("mul 2^16*2^16",1, 0, 32'h0001_0000,  32'h0001_0000, 5'd6,  MUL_LAT, 32'h0000_0000, 1, 0);
      run_op("div -7/2",     0, 1, 32'hFFFF_FFF9,  32'd2,         5'd7,  DIV_LAT, 32'hFFFF_FFFD, 0, 0);
      run_op("div 5/0",      0, 1, 32'd5,          32'd0,         5'd8,  1,       32'h0000_0000, 1, 0);
      run_op("div min/-1",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, DIV_LAT, 32'h8000_0000, 1, 5);
      run_op("both 6,3",     1, 1, 32'd6,          32'd3,         5'd11, MUL_LAT, 32'd18,        0, 0);
      run_op("mul 123*-456", 1, 0, 32'd123,        32'hFFFF_FE38, 5'd12, MUL_LAT, 32'hFFFF_24E8, 0, 0);
      run_op("div 100/-7",   0, 1, 32'd100,        32'hFFFF_FFF9, 5'd13, DIV_LAT, 32'hFFFF_FFF2, 0, 0);
      run_op("mul min*min",  1, 0, 32'h8000_0000,  32'h8000_0000, 5'd14, MUL_LAT, 32'h0000_0000, 1, 0);
      run_op("mul -1*min",   1, 0, 32'hFFFF_FFFF,  32'h8000_0000, 5'd15, MUL_LAT, 32'h8000_0000, 1, 0);

      // Flush on the tenth iteration edge: no pulse, previous result retained.
      bus.ctrl_MULT     = 1'b1;
      bus.data_operandA = 32'd3;
      bus.data_operandB = 32'd5;
      bus.dest_in       = 5'd9;
      tick();
      bus.ctrl_MULT = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush busy", 32'(bus.busy), 32'd0);
      check("flush rdy", 32'(bus.data_resultRDY), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.data_resultRDY === 1'b1) seen = 1;
      end
      check("flush no rdy", 32'(seen), 32'd0);
      check("flush hold", bus.data_result, 32'h8000_0000);
      check("flush dest", 32'(bus.dest_out), 32'd15);
      $display("op flush: busy=%0d rdy_seen=%0d result=%08h", bus.busy, seen, bus.data_result);

      // Reset in the middle of a divide.
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd100;
      bus.data_operandB = 32'd7;
      bus.dest_in       = 5'd4;
      tick();
      bus.ctrl_DIV = 1'b0;
      repeat (5) tick();
      reset = 1'b0;
      tick();
      check("mid rst result", bus.data_result, 32'h0);
      check("mid rst exc", 32'(bus.data_exception), 32'd0);
      check("mid rst rdy", 32'(bus.data_resultRDY), 32'd0);
      check("mid rst dest", 32'(bus.dest_out), 32'd0);
      check("mid rst busy", 32'(bus.busy), 32'd0);
      $display("op reset mid-div: busy=%0d result=%08h", bus.busy, bus.data_result);
      reset = 1'b1;
      tick();

      run_op("mul 3*5",      1, 0, 32'd3,          32'd5,         5'd1,  MUL_LAT, 32'd15,        0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
